sprite_bounce_engine: RTL and testbench
=======================================

Name: sprite_bounce_engine

Overview:
- Parametrised successor to the fixed-tile VGA image path.
- Holds a moving sprite position that updates once per frame on the VGA REFRESH pulse, in either bounce mode or wrap mode.
- Hit-tests every scanned pixel (ADDRH/ADDRV) against the sprite rectangle and generates the sprite ROM address.
- Drives the colour that feeds VGAInterface COLOUR_IN: sprite pixel, background or transparent key. Sits between VGAInterface and a synchronous sprite ROM.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- SPR_W, 80, sprite width
- SPR_H, 80, sprite height
- MARGIN, 5, bounce-mode wall inset in pixels
- X_INIT, 280, reset X; must lie in [XMIN, XMAX]
- Y_INIT, 200, reset Y; must lie in [YMIN, YMAX]
- COLOUR_W, 8, colour width
- BG_COLOUR, 8'h87, background colour
- TRANS_KEY, 8'h00, ROM value treated as transparent
- ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- SPEED_W, 4, speed field width

Ports:
- CLK  in  1  system clock; all logic on posedge
- RESET  in  1  synchronous, active-high
- REFRESH  in  1  one-cycle frame pulse from VGAInterface
- ADDRH  in  10  current horizontal pixel
- ADDRV  in  9  current vertical pixel
- SPEED  in  SPEED_W  pixels moved per frame per axis
- MODE  in  1  0 = bounce, 1 = wrap
- PAUSE  in  1  1 = hold position
- TRANS_EN  in  1  enable the transparent key
- ROM_ADDR  out  ADDR_W  sprite ROM address (registered)
- ROM_DATA  in  COLOUR_W  ROM read data, valid one CLK after ROM_ADDR
- COLOUR_OUT  out  COLOUR_W  pixel colour to VGAInterface COLOUR_IN
- POS_X  out  10  current sprite left edge
- POS_Y  out  9  current sprite top edge
- HIT  out  1  one-cycle pulse on a bounce-mode wall contact

Behaviour:
- Derived limits: XMIN=MARGIN, XMAX=H_RES-SPR_W-MARGIN, YMIN=MARGIN, YMAX=V_RES-SPR_H-MARGIN.
- Reset values: POS_X=X_INIT, POS_Y=Y_INIT, DIRX=DIRY=+, ROM_ADDR=0, inside_d=0, COLOUR_OUT=BG_COLOUR, HIT=0. RESET overrides REFRESH in the same cycle.
- Position update happens only in a cycle with REFRESH=1, RESET=0 and PAUSE=0. SPEED and MODE are sampled in that cycle only. Arithmetic is done in 11 bits with no signed overflow.
- Bounce mode, X axis (Y identical with YMIN/YMAX):
  - DIRX=+ and X+SPEED >= XMAX: X<=XMAX, DIRX<=-, HIT<=1.
  - DIRX=- and X <= XMIN+SPEED: X<=XMIN, DIRX<=+, HIT<=1.
  - Otherwise X <= X±SPEED.
  - Positions are clamped, never overshoot.
- Wrap mode: X <= (X±SPEED) mod H_RES and Y <= (Y±SPEED) mod V_RES. Direction bits unchanged; HIT stays 0.
- If a bounce-mode position is outside its limits when the update happens (e.g. after a MODE switch from wrap), the update clamps it to the violated limit, flips the direction to point inward and pulses HIT.
- HIT is high for exactly the cycle after the update and 0 in every other cycle. A hit on both axes gives a single pulse.
- SPEED=0: position is held; a contact still fires if X is already at a limit and moving into it.
- PAUSE=1 at REFRESH: position and direction are held, HIT=0.
- Pixel pipeline, stage 0 (every cycle):
  - inside = ADDRH>=X && ADDRH<X+SPR_W && ADDRV>=Y && ADDRV<Y+SPR_H, with no wrap-around split.
  - ROM_ADDR <= inside ? (ADDRV-Y)*SPR_W+(ADDRH-X) : 0.
  - inside_d <= inside.
- Pixel pipeline, stage 1: COLOUR_OUT <= BG_COLOUR if !inside_d, or if TRANS_EN && ROM_DATA==TRANS_KEY; otherwise ROM_DATA.
- Latency from ADDRH/ADDRV to COLOUR_OUT is 2 CLK.
- In wrap mode the sprite is clipped at the right and bottom screen edges.

Test Plan:
- Reset: assert RESET 2 cycles -> POS_X=280, POS_Y=200, COLOUR_OUT=0x87, HIT=0, ROM_ADDR=0. Then RESET+REFRESH together -> position unchanged.
- Right-wall bounce: POS_X=552 (XMAX=555), DIRX=+, SPEED=3, REFRESH -> POS_X=555, HIT=1 for one cycle. Next REFRESH -> POS_X=552.
- Pixel fetch: X=280, Y=200, drive ADDRH=281, ADDRV=202 -> next cycle ROM_ADDR=161. With ROM_DATA=0x3C, COLOUR_OUT=0x3C two cycles after drive. ADDRH=279 -> COLOUR_OUT=0x87.
- Transparency: inside pixel, ROM_DATA=0x00 -> TRANS_EN=1 gives COLOUR_OUT=0x87; TRANS_EN=0 gives 0x00.
- Wrap mode: MODE=1, POS_X=630, DIRX=+, SPEED=15, REFRESH -> POS_X=5, HIT=0. DIRX=-, POS_X=3, SPEED=4 -> POS_X=639.
- Pause and mid-operation reset: PAUSE=1 with 3 REFRESH pulses -> position held. RESET mid-frame -> next COLOUR_OUT=0x87, position returns to (280,200).

Source files
------------

// File: rtl/sprite_bounce_engine.sv
// Sprite position engine: per-frame bounce/wrap motion and a 2-cycle
// pixel path (hit-test, ROM address, colour select) into VGAInterface.
module sprite_bounce_engine #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int SPR_W    = 80,
  parameter int SPR_H    = 80,
  parameter int MARGIN   = 5,
  parameter int X_INIT   = 280,
  parameter int Y_INIT   = 200,
  parameter int COLOUR_W = 8,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 'h87,
  parameter logic [COLOUR_W-1:0] TRANS_KEY = 'h00,
  parameter int ADDR_W   = 13,
  parameter int SPEED_W  = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REFRESH,
  input  logic [9:0]          ADDRH,
  input  logic [8:0]          ADDRV,
  input  logic [SPEED_W-1:0]  SPEED,
  input  logic                MODE,
  input  logic                PAUSE,
  input  logic                TRANS_EN,
  output logic [ADDR_W-1:0]   ROM_ADDR,
  input  logic [COLOUR_W-1:0] ROM_DATA,
  output logic [COLOUR_W-1:0] COLOUR_OUT,
  output logic [9:0]          POS_X,
  output logic [8:0]          POS_Y,
  output logic                HIT
);

  localparam logic [10:0] XMIN = 11'(MARGIN);
  localparam logic [10:0] XMAX = 11'(H_RES - SPR_W - MARGIN);
  localparam logic [10:0] YMIN = 11'(MARGIN);
  localparam logic [10:0] YMAX = 11'(V_RES - SPR_H - MARGIN);
  localparam logic [10:0] HRES = 11'(H_RES);
  localparam logic [10:0] VRES = 11'(V_RES);
  localparam logic [10:0] SW   = 11'(SPR_W);
  localparam logic [10:0] SH   = 11'(SPR_H);

  // Returns {hit, dir, pos}; dir=1 means moving towards larger coordinates.
  function automatic logic [12:0] step(
    input logic [10:0] p,
    input logic        d,
    input logic [10:0] s,
    input logic        wrap,
    input logic [10:0] lo,
    input logic [10:0] hi,
    input logic [10:0] res
  );
    logic [10:0] sum;
    logic [10:0] np;
    logic        nd;
    logic        h;
    sum = p + s;
    np  = p;
    nd  = d;
    h   = 1'b0;
    if (wrap) begin
      if (d) np = (sum >= res) ? sum - res : sum;
      else   np = (p >= s) ? p - s : p + res - s;
    end else if (p < lo) begin
      np = lo; nd = 1'b1; h = 1'b1;
    end else if (p > hi) begin
      np = hi; nd = 1'b0; h = 1'b1;
    end else if (d && sum >= hi) begin
      np = hi; nd = 1'b0; h = 1'b1;
    end else if (!d && p <= lo + s) begin
      np = lo; nd = 1'b1; h = 1'b1;
    end else begin
      np = d ? sum : p - s;
    end
    return {h, nd, np};
  endfunction

  logic [9:0]          r_x;
  logic [8:0]          r_y;
  logic                r_dx;
  logic                r_dy;
  logic                r_hit;
  logic                r_inside_d;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [COLOUR_W-1:0] r_colour;

  logic [10:0] w_spd;
  logic [12:0] w_nx;
  logic [12:0] w_ny;
  logic [10:0] w_h;
  logic [10:0] w_v;
  logic [10:0] w_dh;
  logic [10:0] w_dv;
  logic [21:0] w_lin;
  logic        w_inside;
  logic        w_unused;

  assign w_spd = 11'(SPEED);
  assign w_nx  = step(11'(r_x), r_dx, w_spd, MODE, XMIN, XMAX, HRES);
  assign w_ny  = step(11'(r_y), r_dy, w_spd, MODE, YMIN, YMAX, VRES);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_x   <= 10'(X_INIT);
      r_y   <= 9'(Y_INIT);
      r_dx  <= 1'b1;
      r_dy  <= 1'b1;
      r_hit <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (REFRESH && !PAUSE) begin
        r_x   <= w_nx[9:0];
        r_dx  <= w_nx[11];
        r_y   <= w_ny[8:0];
        r_dy  <= w_ny[11];
        r_hit <= w_nx[12] | w_ny[12];
      end
    end
  end

  // Plain rectangle test; off-screen parts of a wrapped sprite are clipped.
  assign w_h      = 11'(ADDRH);
  assign w_v      = 11'(ADDRV);
  assign w_inside = (w_h >= 11'(r_x)) && (w_h < 11'(r_x) + SW) &&
                    (w_v >= 11'(r_y)) && (w_v < 11'(r_y) + SH);
  assign w_dh     = w_h - 11'(r_x);
  assign w_dv     = w_v - 11'(r_y);
  assign w_lin    = 22'(w_dv) * 22'(SPR_W) + 22'(w_dh);
  assign w_unused = ^{w_nx[10], w_ny[10:9], w_lin};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rom_addr <= '0;
      r_inside_d <= 1'b0;
      r_colour   <= BG_COLOUR;
    end else begin
      r_rom_addr <= w_inside ? ADDR_W'(w_lin) : '0;
      r_inside_d <= w_inside;
      if (!r_inside_d || (TRANS_EN && ROM_DATA == TRANS_KEY))
        r_colour <= BG_COLOUR;
      else
        r_colour <= ROM_DATA;
    end
  end

  assign ROM_ADDR   = r_rom_addr;
  assign COLOUR_OUT = r_colour;
  assign POS_X      = r_x;
  assign POS_Y      = r_y;
  assign HIT        = r_hit;

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Randomised bench for sprite_bounce_engine: motion and pixel path
// checked against an integer reference model.
module tb_sprite_bounce_engine;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REFRESH;
  logic [9:0]  ADDRH;
  logic [8:0]  ADDRV;
  logic [3:0]  SPEED;
  logic        MODE;
  logic        PAUSE;
  logic        TRANS_EN;
  logic [12:0] ROM_ADDR;
  logic [7:0]  ROM_DATA;
  logic [7:0]  COLOUR_OUT;
  logic [9:0]  POS_X;
  logic [8:0]  POS_Y;
  logic        HIT;

  logic [7:0] rom [0:8191];

  int errors = 0;
  int checks = 0;

  int mx, my, mdx, mdy;
  bit mhit;

  sprite_bounce_engine dut (
    .CLK(CLK), .RESET(RESET), .REFRESH(REFRESH),
    .ADDRH(ADDRH), .ADDRV(ADDRV), .SPEED(SPEED),
    .MODE(MODE), .PAUSE(PAUSE), .TRANS_EN(TRANS_EN),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .COLOUR_OUT(COLOUR_OUT), .POS_X(POS_X), .POS_Y(POS_Y),
    .HIT(HIT)
  );

  always #5 CLK = ~CLK;

  assign ROM_DATA = rom[ROM_ADDR];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One axis of motion: direction is +1/-1, limits and screen size in pixels.
  task automatic axis(inout int p, inout int d, input int s, input bit wrap,
                      input int lo, input int hi, input int res,
                      inout bit hit);
    int t;
    if (wrap) begin
      p = ((p + d * s) % res + res) % res;
    end else begin
      t = p + d * s;
      if (p < lo) begin
        p = lo; d = 1; hit = 1;
      end else if (p > hi) begin
        p = hi; d = -1; hit = 1;
      end else if ((d > 0 && t >= hi) || (d < 0 && t <= lo)) begin
        p = (d > 0) ? hi : lo; d = -d; hit = 1;
      end else begin
        p = t;
      end
    end
  endtask

  task automatic model_frame(input int s, input bit wrap, input bit pause);
    mhit = 0;
    if (!pause) begin
      axis(mx, mdx, s, wrap, 5, 555, 640, mhit);
      axis(my, mdy, s, wrap, 5, 395, 480, mhit);
    end
  endtask

  function automatic logic [7:0] exp_colour(int h, int v, bit te);
    bit ins;
    logic [7:0] d;
    ins = h >= mx && h < mx + 80 && v >= my && v < my + 80;
    if (!ins) return 8'h87;
    d = rom[(v - my) * 80 + (h - mx)];
    return (te && d == 8'h00) ? 8'h87 : d;
  endfunction

  task automatic do_frame(input int s, input bit mode, input bit pause);
    SPEED = 4'(s); MODE = mode; PAUSE = pause; REFRESH = 1'b1;
    @(posedge CLK);
    model_frame(s, mode, pause);
    @(negedge CLK);
    REFRESH = 1'b0;
  endtask

  task automatic apply_reset;
    RESET = 1'b1; REFRESH = 1'b0; PAUSE = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    mx = 280; my = 200; mdx = 1; mdy = 1;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if (POS_X !== 10'd280) begin errors++; $display("FAIL reset_x: got %0d want 280", POS_X); end
    checks++;
    if (POS_Y !== 9'd200) begin errors++; $display("FAIL reset_y: got %0d want 200", POS_Y); end
    checks++;
    if (COLOUR_OUT !== 8'h87) begin errors++; $display("FAIL reset_colour: got %h want 87", COLOUR_OUT); end
    checks++;
    if (HIT !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", HIT); end
    checks++;
    if (ROM_ADDR !== 13'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", ROM_ADDR); end
    RESET = 1'b1; REFRESH = 1'b1; SPEED = 4'd7;
    @(negedge CLK);
    RESET = 1'b0; REFRESH = 1'b0;
    checks++;
    if (POS_X !== 10'd280 || POS_Y !== 9'd200) begin
      errors++; $display("FAIL reset_refresh: got (%0d,%0d) want (280,200)", POS_X, POS_Y);
    end
  endtask

  task automatic test_right_wall;
    apply_reset();
    repeat (34) do_frame(8, 0, 0);
    checks++;
    if (POS_X !== 10'd552) begin errors++; $display("FAIL wall_pre: got %0d want 552", POS_X); end
    do_frame(3, 0, 0);
    checks++;
    if (POS_X !== 10'd555) begin errors++; $display("FAIL wall_clamp: got %0d want 555", POS_X); end
    checks++;
    if (HIT !== 1'b1) begin errors++; $display("FAIL wall_hit: got %b want 1", HIT); end
    checks++;
    if (POS_Y !== 9'(my)) begin errors++; $display("FAIL wall_y: got %0d want %0d", POS_Y, my); end
    @(negedge CLK);
    checks++;
    if (HIT !== 1'b0) begin errors++; $display("FAIL wall_hit_len: got %b want 0", HIT); end
    do_frame(3, 0, 0);
    checks++;
    if (POS_X !== 10'd552) begin errors++; $display("FAIL wall_back: got %0d want 552", POS_X); end
    checks++;
    if (HIT !== 1'(mhit)) begin errors++; $display("FAIL wall_hit2: got %b want %b", HIT, mhit); end
  endtask

  task automatic test_pixel_fetch;
    apply_reset();
    rom[161] = 8'h3C;
    TRANS_EN = 1'b0;
    ADDRH = 10'd281; ADDRV = 9'd202;
    @(negedge CLK);
    checks++;
    if (ROM_ADDR !== 13'd161) begin errors++; $display("FAIL fetch_addr: got %0d want 161", ROM_ADDR); end
    ADDRH = 10'd279;
    @(negedge CLK);
    checks++;
    if (COLOUR_OUT !== 8'h3C) begin errors++; $display("FAIL fetch_colour: got %h want 3c", COLOUR_OUT); end
    checks++;
    if (ROM_ADDR !== 13'd0) begin errors++; $display("FAIL fetch_addr_out: got %0d want 0", ROM_ADDR); end
    @(negedge CLK);
    checks++;
    if (COLOUR_OUT !== 8'h87) begin errors++; $display("FAIL fetch_bg: got %h want 87", COLOUR_OUT); end
  endtask

  task automatic test_transparency;
    rom[405] = 8'h00;
    TRANS_EN = 1'b1; ADDRH = 10'd285; ADDRV = 9'd205;
    repeat (2) @(negedge CLK);
    checks++;
    if (COLOUR_OUT !== 8'h87) begin errors++; $display("FAIL trans_on: got %h want 87", COLOUR_OUT); end
    TRANS_EN = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (COLOUR_OUT !== 8'h00) begin errors++; $display("FAIL trans_off: got %h want 00", COLOUR_OUT); end
  endtask

  task automatic test_wrap;
    apply_reset();
    repeat (35) do_frame(10, 1, 0);
    checks++;
    if (POS_X !== 10'd630) begin errors++; $display("FAIL wrap_pre: got %0d want 630", POS_X); end
    do_frame(15, 1, 0);
    checks++;
    if (POS_X !== 10'd5) begin errors++; $display("FAIL wrap_right: got %0d want 5", POS_X); end
    checks++;
    if (HIT !== 1'b0) begin errors++; $display("FAIL wrap_hit: got %b want 0", HIT); end
    checks++;
    if (POS_Y !== 9'(my)) begin errors++; $display("FAIL wrap_y: got %0d want %0d", POS_Y, my); end
    apply_reset();
    repeat (19) do_frame(15, 0, 0);
    checks++;
    if (POS_X !== 10'd555) begin errors++; $display("FAIL wrap_turn: got %0d want 555", POS_X); end
    repeat (69) do_frame(8, 1, 0);
    checks++;
    if (POS_X !== 10'd3) begin errors++; $display("FAIL wrap_pre_left: got %0d want 3", POS_X); end
    do_frame(4, 1, 0);
    checks++;
    if (POS_X !== 10'd639) begin errors++; $display("FAIL wrap_left: got %0d want 639", POS_X); end
    checks++;
    if (POS_Y !== 9'(my)) begin errors++; $display("FAIL wrap_left_y: got %0d want %0d", POS_Y, my); end
  endtask

  task automatic test_pause_and_reset;
    int px, py;
    apply_reset();
    do_frame(5, 0, 0);
    px = mx; py = my;
    for (int i = 0; i < 3; i++) begin
      do_frame(9, 1'($urandom_range(0, 1)), 1);
      checks++;
      if (POS_X !== 10'(px) || POS_Y !== 9'(py) || HIT !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold: got (%0d,%0d,%b) want (%0d,%0d,0)", POS_X, POS_Y, HIT, px, py);
      end
    end
    rom[20 * 80 + 20] = 8'h5A;
    TRANS_EN = 1'b1; ADDRH = 10'd300; ADDRV = 9'd220;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (COLOUR_OUT !== 8'h87) begin errors++; $display("FAIL midreset_colour: got %h want 87", COLOUR_OUT); end
    checks++;
    if (POS_X !== 10'd280 || POS_Y !== 9'd200) begin
      errors++; $display("FAIL midreset_pos: got (%0d,%0d) want (280,200)", POS_X, POS_Y);
    end
    checks++;
    if (ROM_ADDR !== 13'd0 || HIT !== 1'b0) begin
      errors++; $display("FAIL midreset_regs: got addr %0d hit %b want 0 0", ROM_ADDR, HIT);
    end
    RESET = 1'b0;
    mx = 280; my = 200; mdx = 1; mdy = 1;
    repeat (2) @(negedge CLK);
    checks++;
    if (COLOUR_OUT !== 8'h5A) begin errors++; $display("FAIL midreset_resume: got %h want 5a", COLOUR_OUT); end
  endtask

  task automatic test_random_motion;
    int s;
    bit m, p;
    apply_reset();
    for (int i = 0; i < 150; i++) begin
      s = $urandom_range(0, 15);
      m = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      do_frame(s, m, p);
      checks++;
      if (POS_X !== 10'(mx) || POS_Y !== 9'(my) || HIT !== 1'(mhit)) begin
        errors++;
        $display("FAIL rand_frame%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)",
                 i, POS_X, POS_Y, HIT, mx, my, mhit);
      end
      @(negedge CLK);
      checks++;
      if (HIT !== 1'b0) begin errors++; $display("FAIL rand_hit_len%0d: got %b want 0", i, HIT); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] e;
    int h, v;
    TRANS_EN = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (k >= 2) begin
        e = q.pop_front();
        checks++;
        if (COLOUR_OUT !== e) begin errors++; $display("FAIL b2b_pix%0d: got %h want %h", k, COLOUR_OUT, e); end
      end
      h = mx - 6 + $urandom_range(0, 92);
      v = my - 6 + $urandom_range(0, 92);
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      if (v < 0) v = 0;
      if (v > 511) v = 511;
      ADDRH = 10'(h); ADDRV = 9'(v);
      q.push_back(exp_colour(h, v, 1'b1));
      @(negedge CLK);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++)
      rom[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    RESET = 1'b1; REFRESH = 1'b0; ADDRH = '0; ADDRV = '0;
    SPEED = '0; MODE = 1'b0; PAUSE = 1'b0; TRANS_EN = 1'b0;
    test_reset();
    test_right_wall();
    test_pixel_fetch();
    test_transparency();
    test_wrap();
    test_pause_and_reset();
    test_random_motion();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
